// File: rtl/pos_logic_pipe.sv
// pos_logic_pipe: two-stage valid/ready bitwise logic unit with zero/parity/popcount flags
// and a saturating output-transfer counter.
module pos_logic_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  localparam int ONES_W = $clog2(WIDTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [2:0]        i_op,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_out,
  output logic              o_zero,
  output logic              o_parity,
  output logic [ONES_W-1:0] o_ones,
  input  logic              i_cnt_clr,
  output logic [CNT_W-1:0]  o_xfer_cnt
);
  logic              r_s1_valid;
  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s1_data;
  logic [WIDTH-1:0]  r_out;
  logic              r_zero;
  logic              r_parity;
  logic [ONES_W-1:0] r_ones;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  w_res;
  logic [ONES_W-1:0] w_ones;
  logic              w_s2_adv;
  assign w_s2_adv    = !r_s2_valid || i_out_ready;
  assign o_in_ready  = !r_s1_valid || w_s2_adv;
  assign o_out_valid = r_s2_valid;
  assign o_out       = r_out;
  assign o_zero      = r_zero;
  assign o_parity    = r_parity;
  assign o_ones      = r_ones;
  assign o_xfer_cnt  = r_cnt;
  always_comb begin
    case (i_op)
      3'd0:    w_res = i_a & i_b;
      3'd1:    w_res = i_a | i_b;
      3'd2:    w_res = i_a ^ i_b;
      3'd3:    w_res = ~(i_a ^ i_b);
      3'd4:    w_res = ~(i_a & i_b);
      3'd5:    w_res = ~(i_a | i_b);
      3'd6:    w_res = ~i_a;
      default: w_res = i_b;
    endcase
  end
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) w_ones = w_ones + ONES_W'(r_s1_data[i]);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (o_in_ready) begin
      r_s1_valid <= i_in_valid;
      r_s1_data  <= w_res;
    end
  end
  // Flags are computed from stage 1 so the outputs come straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zero     <= 1'b0;
      r_parity   <= 1'b0;
      r_ones     <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_out      <= r_s1_data;
      r_zero     <= ~|r_s1_data;
      r_parity   <= ^r_s1_data;
      r_ones     <= w_ones;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_cnt_clr) r_cnt <= '0;
    else if (r_s2_valid && i_out_ready && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pos_logic_pipe.sv
// tb_pos_logic_pipe: directed table vectors plus hand-written stall, counter and reset sequences.
module tb_pos_logic_pipe;
  localparam int W = 16;
  localparam int N = 12;
  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic z;
    logic p;
    logic [4:0] ones;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cnt_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0] op = '0;
  logic in_ready, out_valid, zero, parity;
  logic in_ready2, out_valid2, zero2, parity2;
  logic [W-1:0] out, out2;
  logic [4:0] ones, ones2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int checks = 0;
  int errors = 0;
  vec_t tv[N];

  always #5 clk = ~clk;

  pos_logic_pipe #(.WIDTH(W), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_op(op), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out(out), .o_zero(zero), .o_parity(parity), .o_ones(ones),
    .i_cnt_clr(cnt_clr), .o_xfer_cnt(cnt)
  );

  pos_logic_pipe #(.WIDTH(W), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready2),
    .i_a(a), .i_b(b), .i_op(op), .o_out_valid(out_valid2), .i_out_ready(out_ready),
    .o_out(out2), .o_zero(zero2), .o_parity(parity2), .o_ones(ones2),
    .i_cnt_clr(cnt_clr), .o_xfer_cnt(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, total;
    tv[0]  = '{3'd2, 16'h0000, 16'h68AF, 16'h68AF, 1'b0, 1'b1, 5'd9};
    tv[1]  = '{3'd2, 16'hFFFF, 16'hFF55, 16'h00AA, 1'b0, 1'b0, 5'd4};
    tv[2]  = '{3'd2, 16'h0000, 16'hCCCC, 16'hCCCC, 1'b0, 1'b0, 5'd8};
    tv[3]  = '{3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 5'd4};
    tv[4]  = '{3'd1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 5'd12};
    tv[5]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 5'd8};
    tv[6]  = '{3'd3, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0, 5'd8};
    tv[7]  = '{3'd4, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 5'd12};
    tv[8]  = '{3'd5, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0, 5'd4};
    tv[9]  = '{3'd6, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0, 5'd8};
    tv[10] = '{3'd7, 16'hF0F0, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 5'd8};
    tv[11] = '{3'd0, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0, 5'd0};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_parity", parity, 0);
    chk("rst_ones", ones, 0);
    chk("rst_cnt", cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Streamed table: beat i is accepted on edge i and visible after edge i+1.
    out_ready = 1'b1;
    for (int i = 0; i <= N + 1; i++) begin
      in_valid = (i < N);
      if (i < N) begin
        op = tv[i].op;
        a = tv[i].a;
        b = tv[i].b;
        #1 chk("tput_in_ready", in_ready, 1);
      end
      step();
      if (i >= 1 && i <= N) begin
        chk($sformatf("v%0d_valid", i - 1), out_valid, 1);
        chk($sformatf("v%0d_out", i - 1), out, tv[i-1].out);
        chk($sformatf("v%0d_zero", i - 1), zero, tv[i-1].z);
        chk($sformatf("v%0d_parity", i - 1), parity, tv[i-1].p);
        chk($sformatf("v%0d_ones", i - 1), ones, tv[i-1].ones);
      end
      if (i == 4) chk("cnt_after_3", cnt, 3);
    end
    chk("drain_valid", out_valid, 0);
    chk("stream_cnt", cnt, N);
    chk("sat_cnt", cnt2, 3);

    // Backpressure: two beats fill the pipe, the third is refused.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnt", cnt, 0);
    out_ready = 1'b0;
    op = 3'd7;
    in_valid = 1'b1;
    a = 16'h0;
    b = 16'h1000;
    step();
    b = 16'h1001;
    step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_out", out, 16'h1000);
    b = 16'h1002;
    step();
    chk("bp_hold_out", out, 16'h1000);
    chk("bp_hold_ones", ones, 1);
    chk("bp_hold_ready", in_ready, 0);

    sent = 2;
    got = 0;
    total = 14;
    for (int cyc = 0; cyc < 400 && got < total; cyc++) begin
      in_valid = (sent < total);
      b = 16'h1000 + 16'(sent);
      a = ~b;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        chk("order_out", out, 16'h1000 + 16'(got));
        chk("order_ones", ones, 5'($countones(16'h1000 + 16'(got))));
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("delivered", got, total);
    chk("bp_cnt", cnt, total);
    chk("bp_sat_cnt", cnt2, 3);

    // Clear wins over a concurrent transfer.
    out_ready = 1'b0;
    in_valid = 1'b1;
    b = 16'h2222;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_valid", out_valid, 1);
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_xfer_cnt", cnt, 0);
    chk("clr_xfer_sat", cnt2, 0);
    chk("clr_xfer_valid", out_valid, 0);

    // Asynchronous reset with both stages full.
    in_valid = 1'b1;
    b = 16'h3333;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_cnt", cnt, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    b = 16'h4444;
    step();
    b = 16'h5555;
    step();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_out", out, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_ones", ones, 0);
    step();
    rst_n = 1'b1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    b = 16'h6666;
    step();
    in_valid = 1'b0;
    chk("lat1_valid", out_valid, 0);
    step();
    chk("lat2_valid", out_valid, 1);
    chk("lat2_out", out, 16'h6666);
    chk("lat2_ones", ones, 8);
    chk("lat2_parity", parity, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
